// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte stream (4-byte LE length, payload, checksum) into
// byte writes for the instruction ROM, holding the CPU in reset until the image verifies.
module imem_loader #(
    parameter int unsigned W   = 32,
    parameter int unsigned WAD = 16,
    parameter int unsigned WB  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [WB-1:0]  rx_data,
    input  logic           rx_valid,
    output logic           rx_ready,
    output logic           we,
    output logic [WAD-1:0] waddr,
    output logic [WB-1:0]  wdata,
    output logic           cpu_hold,
    output logic           done,
    output logic           err,
    output logic [WAD:0]   bytes_ld
);

    typedef enum logic [2:0] {StIdle, StHdr, StLoad, StChk, StDone, StErr} state_e;

    localparam logic [W-1:0] MaxLen = W'(64'd1 << WAD);

    state_e         state_q, state_d;
    logic [W-1:0]   len_q, len_d;
    logic [WAD:0]   cnt_q, cnt_d;
    logic [WB-1:0]  sum_q, sum_d;
    logic [1:0]     hdr_cnt_q, hdr_cnt_d;
    logic [WAD:0]   bytes_ld_q, bytes_ld_d;
    logic           we_q, we_d;
    logic [WAD-1:0] waddr_q, waddr_d;
    logic [WB-1:0]  wdata_q, wdata_d;

    logic           xfer;
    logic [W-1:0]   len_full;
    logic           last_payload;

    assign xfer         = rx_valid & rx_ready;
    // Header bytes arrive LSB first, so shift each new byte in from the top.
    assign len_full     = {rx_data, len_q[W-1:WB]};
    assign last_payload = (W'(cnt_q) == (len_q - W'(1)));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        hdr_cnt_d  = hdr_cnt_q;
        bytes_ld_d = bytes_ld_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;

        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d    = StHdr;
                    len_d      = '0;
                    cnt_d      = '0;
                    sum_d      = '0;
                    hdr_cnt_d  = '0;
                    bytes_ld_d = '0;
                end
            end
            StHdr: begin
                if (xfer) begin
                    len_d     = len_full;
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'd3) begin
                        if (len_full > MaxLen) begin
                            state_d = StErr;
                        end else if (len_full == '0) begin
                            state_d = StChk;
                        end else begin
                            state_d = StLoad;
                        end
                    end
                end
            end
            StLoad: begin
                if (xfer) begin
                    we_d       = 1'b1;
                    waddr_d    = cnt_q[WAD-1:0];
                    wdata_d    = rx_data;
                    sum_d      = sum_q + rx_data;
                    cnt_d      = cnt_q + 1'b1;
                    bytes_ld_d = bytes_ld_q + 1'b1;
                    if (last_payload) begin
                        state_d = StChk;
                    end
                end
            end
            StChk: begin
                if (xfer) begin
                    state_d = (rx_data == sum_q) ? StDone : StErr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            len_q      <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            hdr_cnt_q  <= '0;
            bytes_ld_q <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            hdr_cnt_q  <= hdr_cnt_d;
            bytes_ld_q <= bytes_ld_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Status outputs decode registered state only; rx_ready never depends on rx_valid.
    assign rx_ready = (state_q == StHdr) || (state_q == StLoad) || (state_q == StChk);
    assign done     = (state_q == StDone);
    assign err      = (state_q == StErr);
    assign cpu_hold = (state_q != StDone);
    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign bytes_ld = bytes_ld_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are driven on the falling edge, outputs sampled there too.
module tb_imem_loader;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        we;
    logic [15:0] waddr;
    logic [7:0]  wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [16:0] bytes_ld;

    int checks   = 0;
    int failures = 0;
    int xfers    = 0;

    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];
    logic [7:0]  mem [0:255];

    imem_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err),
        .bytes_ld (bytes_ld)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we === 1'b1) begin
            wa_q.push_back(waddr);
            wd_q.push_back(wdata);
            mem[waddr[7:0]] = wdata;
        end
        if (rx_valid === 1'b1 && rx_ready === 1'b1) xfers++;
    end

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        xfers = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int maxgap);
        int n;
        if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (rx_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_timeout actual rx_ready=%b required=1 byte=%02h", rx_ready, b);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bq_t f, input int maxgap);
        foreach (f[i]) send(f[i], maxgap);
    endtask

    // Payload 13 05 10 00 sums to 0x28 mod 256.
    task automatic check_t1_writes(input string tag);
        logic [7:0] exp_d[4];
        exp_d = '{8'h13, 8'h05, 8'h10, 8'h00};
        checks++;
        if (wa_q.size() != 4) begin
            failures++;
            $display("FAIL %s_wcount actual=%0d required=4", tag, wa_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wa_q[i] !== 16'(i) || wd_q[i] !== exp_d[i]) begin
                    failures++;
                    $display("FAIL %s_write%0d actual=%04h:%02h required=%04h:%02h",
                             tag, i, wa_q[i], wd_q[i], i, exp_d[i]);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || err !== 1'b0 || bytes_ld !== 17'd4) begin
            failures++;
            $display("FAIL %s_done actual done=%b hold=%b err=%b bytes=%0d required 1 0 0 4",
                     tag, done, cpu_hold, err, bytes_ld);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rx_ready !== 1'b0 || we !== 1'b0 || waddr !== 16'h0 || wdata !== 8'h0) begin
            failures++;
            $display("FAIL reset_bus actual ready=%b we=%b waddr=%h wdata=%h required 0 0 0 0",
                     rx_ready, we, waddr, wdata);
        end
        checks++;
        if (cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0 || bytes_ld !== 17'd0) begin
            failures++;
            $display("FAIL reset_status actual hold=%b done=%b err=%b bytes=%0d required 1 0 0 0",
                     cpu_hold, done, err, bytes_ld);
        end
        rst = 1'b0;
        clear_log();
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if (xfers != 0 || rx_ready !== 1'b0 || bytes_ld !== 17'd0) begin
            failures++;
            $display("FAIL idle_ignore actual xfers=%0d ready=%b required 0 0", xfers, rx_ready);
        end
    endtask

    task automatic test_basic();
        clear_log();
        pulse_start();
        checks++;
        if (rx_ready !== 1'b1 || cpu_hold !== 1'b1) begin
            failures++;
            $display("FAIL basic_armed actual ready=%b hold=%b required 1 1", rx_ready, cpu_hold);
        end
        send_frame('{8'h04, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h28}, 0);
        check_t1_writes("basic");
        checks++;
        if ({mem[3], mem[2], mem[1], mem[0]} !== 32'h0010_0513) begin
            failures++;
            $display("FAIL basic_word actual=%h required=00100513",
                     {mem[3], mem[2], mem[1], mem[0]});
        end
        checks++;
        if (rx_ready !== 1'b0 || we !== 1'b0) begin
            failures++;
            $display("FAIL basic_quiet actual ready=%b we=%b required 0 0", rx_ready, we);
        end
    endtask

    task automatic test_bad_checksum();
        clear_log();
        pulse_start();
        send_frame('{8'h04, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h3B}, 0);
        checks++;
        if (err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL badsum_err actual err=%b done=%b hold=%b ready=%b required 1 0 1 0",
                     err, done, cpu_hold, rx_ready);
        end
        clear_log();
        pulse_start();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL badsum_clear actual err=%b required 0", err);
        end
        send_frame('{8'h04, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h28}, 0);
        check_t1_writes("retry");
    endtask

    task automatic test_overflow();
        clear_log();
        pulse_start();
        send_frame('{8'h01, 8'h00, 8'h01, 8'h00}, 0);
        checks++;
        if (err !== 1'b1 || rx_ready !== 1'b0 || wa_q.size() != 0 || cpu_hold !== 1'b1) begin
            failures++;
            $display("FAIL overflow actual err=%b ready=%b writes=%0d hold=%b required 1 0 0 1",
                     err, rx_ready, wa_q.size(), cpu_hold);
        end
        // Exactly 2**WAD is a legal length and must enter the payload phase.
        pulse_start();
        send_frame('{8'h00, 8'h00, 8'h01, 8'h00}, 0);
        checks++;
        if (err !== 1'b0 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL maxlen_accept actual err=%b ready=%b required 0 1", err, rx_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_flow_control();
        clear_log();
        pulse_start();
        send_frame('{8'h04, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h28}, 4);
        check_t1_writes("flow");
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if (xfers != 9 || bytes_ld !== 17'd4 || done !== 1'b1) begin
            failures++;
            $display("FAIL flow_xfers actual xfers=%0d bytes=%0d done=%b required 9 4 1",
                     xfers, bytes_ld, done);
        end
    endtask

    task automatic test_start_ignored();
        clear_log();
        pulse_start();
        send_frame('{8'h04, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05}, 0);
        pulse_start();
        checks++;
        if (bytes_ld !== 17'd2 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_ignored actual bytes=%0d ready=%b required 2 1",
                     bytes_ld, rx_ready);
        end
        send_frame('{8'h10, 8'h00, 8'h28}, 0);
        check_t1_writes("midstart");
    endtask

    task automatic test_reset_mid_load();
        clear_log();
        pulse_start();
        send_frame('{8'h04, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05}, 0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b0 || we !== 1'b0 || waddr !== 16'h0 || wdata !== 8'h0 ||
            cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0 || bytes_ld !== 17'd0) begin
            failures++;
            $display("FAIL midrst actual ready=%b we=%b wa=%h wd=%h hold=%b done=%b err=%b n=%0d",
                     rx_ready, we, waddr, wdata, cpu_hold, done, err, bytes_ld);
        end
        rst = 1'b0;
        clear_log();
        pulse_start();
        send_frame('{8'h04, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h28}, 0);
        check_t1_writes("postrst");
    endtask

    task automatic test_zero_length();
        clear_log();
        pulse_start();
        send_frame('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0);
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || wa_q.size() != 0 || bytes_ld !== 17'd0) begin
            failures++;
            $display("FAIL zero_len actual done=%b hold=%b writes=%0d bytes=%0d required 1 0 0 0",
                     done, cpu_hold, wa_q.size(), bytes_ld);
        end
        pulse_start();
        checks++;
        if (cpu_hold !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL rearm actual hold=%b done=%b ready=%b required 1 0 1",
                     cpu_hold, done, rx_ready);
        end
        clear_log();
        send_frame('{8'h04, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h28}, 0);
        check_t1_writes("rearm");
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        test_reset();
        test_basic();
        test_bad_checksum();
        test_overflow();
        test_flow_control();
        test_start_ignored();
        test_reset_mid_load();
        test_zero_length();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
